// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: opcode values, instruction
// field widths and the issuer FSM state encoding.
package instr_issuer_pkg;

  localparam int OP_W   = 4;
  localparam int REG_W  = 4;
  localparam int WORD_W = OP_W + 2 * REG_W;

  // Flow-control opcodes consumed by the issuer itself, never sent to the decoder
  localparam logic [OP_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // Opcodes understood by the downstream decoder's ALU
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_INC = 4'h8,
    OP_DEC = 4'h9,
    OP_MOV = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // True for the opcodes that steer the issuer instead of being issued
  function automatic logic is_flow_op(input logic [OP_W-1:0] op);
    return (op == OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program memory: synchronous write port, registered read port with one cycle
// of latency. Contents are deliberately not touched by reset.
module instr_mem
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [CODE_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [CODE_W-1:0]        rdata
);

  logic [CODE_W-1:0] mem [DEPTH];

  // Write the addressed word and register the word at the read address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: walks the program memory from address 0, consumes JMP and
// HALT locally and hands every other word to the decoder over a valid/ready
// handshake. Each instruction costs a FETCH cycle plus at least one ISSUE cycle.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [CODE_W-1:0]        prog_data,
  output logic [CODE_W-1:0]        code,
  output logic                     code_valid,
  input  logic                     code_ready,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state;
  logic [CODE_W-1:0] word;
  logic [OP_W-1:0]   op;
  logic              mem_we;

  assign op = word[CODE_W-1 -: OP_W];

  // The program may only change while nothing is being fetched, and reset blocks it
  assign mem_we = prog_we && !rst && ((state == IDLE) || (state == DONE));

  instr_mem #(
    .DEPTH  (DEPTH),
    .CODE_W (CODE_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (word)
  );

  // Offer the fetched word in ISSUE; pc and memory are frozen there, so it stays stable
  always_comb begin
    code_valid = (state == ISSUE) && !is_flow_op(op);
    code       = code_valid ? word : '0;
  end

  // Sequencer: program counter, issue counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      issued_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FETCH;
            pc         <= '0;
            issued_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        FETCH: begin
          state <= ISSUE;
        end
        ISSUE: begin
          if (op == OP_HALT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (op == OP_JMP) begin
            state <= FETCH;
            pc    <= word[AW-1:0];
          end else if (code_ready) begin
            state <= FETCH;
            pc    <= pc + PC_ONE;
            if (issued_cnt != CNT_MAX) begin
              issued_cnt <= issued_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed program scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic [11:0] code;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [7:0]  issued_cnt;

  instr_issuer #(
    .DEPTH  (16),
    .CODE_W (12),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .issued_cnt (issued_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Edge counter used to time handshakes
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: mode 0 idle, 1 waiting for the memory word,
  // 2 word available for issue, 3 halted
  int          m_mode  = 0;
  int          m_pc    = 0;
  int          m_cnt   = 0;
  bit          model_on = 0;
  logic [11:0] m_mem [16];

  logic [11:0] log_code [$];
  int          log_edge [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model, then model advance on the clock edge
  initial begin
    logic [11:0] w;
    bit          exp_valid;
    forever begin
      @(negedge clk);
      if (model_on) begin
        w = m_mem[m_pc];
        exp_valid = (m_mode == 2) && (w[11:8] != 4'hF) && (w[11:8] != 4'hB);
        checkOutput("code_valid", code_valid, exp_valid);
        if (exp_valid) checkOutput("code", code, w);
        checkOutput("busy", busy, (m_mode == 1) || (m_mode == 2));
        checkOutput("done", done, m_mode == 3);
        checkOutput("pc", pc, m_pc);
        checkOutput("issued_cnt", issued_cnt, m_cnt);
        if (code_valid && code_ready && !rst && !abort) begin
          log_code.push_back(code);
          log_edge.push_back(cyc + 1);
        end
      end
      @(posedge clk);
      if (rst) begin
        m_mode   = 0;
        m_pc     = 0;
        m_cnt    = 0;
        model_on = 1;
      end else if (model_on) begin
        if (prog_we && (m_mode == 0 || m_mode == 3)) m_mem[prog_addr] = prog_data;
        if (abort) begin
          m_mode = 0;
        end else begin
          case (m_mode)
            0, 3: if (start) begin m_pc = 0; m_cnt = 0; m_mode = 1; end
            1: m_mode = 2;
            default: begin
              w = m_mem[m_pc];
              if (w[11:8] == 4'hF) begin
                m_mode = 3;
              end else if (w[11:8] == 4'hB) begin
                m_pc   = w[3:0];
                m_mode = 1;
              end else if (code_ready) begin
                m_pc   = (m_pc + 1) % 16;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_mode = 1;
              end
            end
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic we,
                               input logic [3:0] addr, input logic [11:0] data);
    start     = s;
    abort     = a;
    prog_we   = we;
    prog_addr = addr;
    prog_data = data;
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic loadWord(input logic [3:0] addr, input logic [11:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic clearLog();
    log_code.delete();
    log_edge.delete();
  endtask

  task automatic runUntilDone(input int limit, input string name);
    int k = 0;
    while (!done && k < limit) begin
      tick();
      k++;
    end
    checkOutput(name, done, 1'b1);
  endtask

  task automatic waitLog(input int n, input int limit, input string name);
    int k = 0;
    while (log_code.size() < n && k < limit) begin
      tick();
      k++;
    end
    checkOutput(name, log_code.size(), n);
  endtask

  task automatic checkLog(input int idx, input logic [11:0] exp_code, input int exp_edge, input string name);
    if (log_code.size() > idx) begin
      checkOutput({name, "_code"}, log_code[idx], exp_code);
      if (exp_edge >= 0) checkOutput({name, "_edge"}, log_edge[idx], exp_edge);
    end else begin
      checkOutput({name, "_present"}, log_code.size(), idx + 1);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_code_valid"}, code_valid, 1'b0);
    checkOutput({tag, "_code"}, code, 12'h000);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_pc"}, pc, 4'd0);
    checkOutput({tag, "_cnt"}, issued_cnt, 8'd0);
  endtask

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; code_ready = 1'b0;
    repeat (2) tick();
    checkResetState("reset");
    rst = 1'b0;
    for (int a = 0; a < 16; a++) loadWord(a[3:0], 12'hF00);

    $display("[TB] straight issue");
    loadWord(4'd0, 12'h121); loadWord(4'd1, 12'h212); loadWord(4'd2, 12'hF00);
    clearLog();
    code_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    n0 = cyc;
    runUntilDone(20, "s1_done");
    checkOutput("s1_issues", log_code.size(), 2);
    checkLog(0, 12'h121, n0 + 2, "s1_first");
    checkLog(1, 12'h212, n0 + 4, "s1_second");
    checkOutput("s1_cnt", issued_cnt, 8'd2);
    checkOutput("s1_pc", pc, 4'd2);

    $display("[TB] backpressure");
    loadWord(4'd1, 12'hF00);
    code_ready = 1'b0;
    clearLog();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("s2_hold_valid", code_valid, 1'b1);
      checkOutput("s2_hold_code", code, 12'h121);
      tick();
    end
    code_ready = 1'b1;
    runUntilDone(20, "s2_done");
    checkOutput("s2_issues", log_code.size(), 1);
    checkLog(0, 12'h121, -1, "s2_first");
    checkOutput("s2_cnt", issued_cnt, 8'd1);

    $display("[TB] jump and wrap");
    loadWord(4'd0, 12'hB0E); loadWord(4'd14, 12'h534); loadWord(4'd15, 12'h645);
    clearLog();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    n0 = cyc;
    repeat (6) tick();
    checkOutput("s3_wrap_pc", pc, 4'd0);
    checkOutput("s3_wrap_busy", busy, 1'b1);
    waitLog(3, 20, "s3_issues");
    checkLog(0, 12'h534, n0 + 4, "s3_first");
    checkLog(1, 12'h645, n0 + 6, "s3_second");
    checkLog(2, 12'h534, n0 + 10, "s3_refetch");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 12'h000);

    $display("[TB] abort");
    loadWord(4'd0, 12'h121); loadWord(4'd1, 12'h212); loadWord(4'd2, 12'hF00);
    code_ready = 1'b0;
    clearLog();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    tick();
    checkOutput("s4_valid_before", code_valid, 1'b1);
    code_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 12'h000);
    code_ready = 1'b0;
    checkOutput("s4_busy", busy, 1'b0);
    checkOutput("s4_valid", code_valid, 1'b0);
    checkOutput("s4_cnt", issued_cnt, 8'd0);
    checkOutput("s4_pc", pc, 4'd0);
    checkOutput("s4_issues", log_code.size(), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 12'h000);
    checkOutput("s4_abort_wins", busy, 1'b0);
    code_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 12'h3AB);
    runUntilDone(20, "s4_done");
    checkLog(0, 12'h3AB, -1, "s4_write_start");
    checkLog(1, 12'h212, -1, "s4_after_write");

    $display("[TB] writes while busy and reset");
    code_ready = 1'b0;
    clearLog();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 12'h777);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 12'h888);
    code_ready = 1'b1;
    runUntilDone(20, "s5_done");
    checkLog(0, 12'h3AB, -1, "s5_first");
    checkLog(1, 12'h212, -1, "s5_second");
    clearLog();
    code_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    tick();
    code_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("s5_rst");
    checkOutput("s5_rst_issues", log_code.size(), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    runUntilDone(20, "s5_rerun_done");
    checkLog(0, 12'h3AB, -1, "s5_rerun_first");
    checkLog(1, 12'h212, -1, "s5_rerun_second");

    $display("[TB] saturation");
    loadWord(4'd0, 12'h121); loadWord(4'd1, 12'hB00);
    clearLog();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
    waitLog(300, 2000, "s6_issues");
    checkOutput("s6_cnt_sat", issued_cnt, 8'd255);
    checkLog(299, 12'h121, -1, "s6_last");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 12'h000);
    checkOutput("s6_abort_cnt", issued_cnt, 8'd255);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 255) == 0);
      prog_we    = ($urandom_range(0, 2) == 0);
      prog_addr  = 4'($urandom_range(0, 15));
      prog_data  = 12'($urandom_range(0, 4095));
      code_ready = 1'($urandom_range(0, 1));
      tick();
      if (log_code.size() > 64) clearLog();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; prog_we = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
